// File: rtl/jt12_wr_queue_pkg.sv
// jt12_wr_queue_pkg: shared FSM states and queue entry layout for the jt12 write queue
package jt12_wr_queue_pkg;
  localparam int ENTRY_W = 17;
  typedef enum logic [2:0] {S_IDLE, S_AWAIT, S_AWR, S_AGAP, S_DWAIT, S_DWR, S_DGAP} state_t;
  typedef struct packed {
    logic       part;
    logic [7:0] rg;
    logic [7:0] data;
  } entry_t;
endpackage

// File: rtl/jt12_wr_queue_fifo.sv
// jt12_wr_queue_fifo: sync FIFO of {part,reg,data}; ports push_i/pop_i/flush_i/din_i in, dout_o/level_o/full_o/empty_o out
module jt12_wr_queue_fifo
  import jt12_wr_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        din_i,
  output entry_t        dout_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  always_ff @(posedge clk)
    if (push_i) mem[wp_q] <= din_i;
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(push_i);
      rp_q    <= rp_q + AW'(pop_i);
      level_q <= level_q + LW'(push_i) - LW'(pop_i);
    end
  assign dout_o  = entry_t'(mem[rp_q]);
  assign level_o = level_q;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
endmodule

// File: rtl/jt12_wr_queue.sv
// jt12_wr_queue: queued YM2612 register writer; req_* in, cs_n/wr_n/addr/dout bus out, busy polled, level/overflow/idle status
module jt12_wr_queue
  import jt12_wr_queue_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int STROBE     = 1,
  parameter int GAP        = 2,
  parameter int ADDR_CACHE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_part,
  input  logic [7:0]               req_reg,
  input  logic [7:0]               req_data,
  input  logic                     flush,
  input  logic                     busy,
  output logic                     cs_n,
  output logic                     wr_n,
  output logic [1:0]               addr,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     idle
);
  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int MAXT = STROBE > GAP ? STROBE : GAP;
  localparam int CW   = $clog2(MAXT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t cur_q, cur_d, head;
  logic [1:0] vld_q;
  logic [1:0][7:0] creg_q;
  logic ov_q, stb_n_q, stb_n_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic full, empty, pop, push, hit, tick_end, cache_set;
  logic [LW-1:0] fifo_level;

  jt12_wr_queue_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   ({req_part, req_reg, req_data}),
    .dout_o  (head),
    .level_o (fifo_level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign push      = req_valid && !flush && (!full || pop);
  assign hit       = ADDR_CACHE != 0 && vld_q[head.part] && creg_q[head.part] == head.rg;
  assign tick_end  = cnt_q == '0;
  assign cache_set = cen && state_q == S_AWR && tick_end;
  assign cur_d     = pop ? head : cur_q;

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      vld_q   <= '0;
      creg_q  <= '0;
      ov_q    <= 1'b0;
      stb_n_q <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      vld_q   <= flush ? '0 : cache_set ? vld_q | (2'b01 << cur_q.part) : vld_q;
      if (cache_set) creg_q[cur_q.part] <= cur_q.rg;
      ov_q    <= !flush && (ov_q || (req_valid && !push));
      stb_n_q <= stb_n_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    if (cen)
      case (state_q)
        S_IDLE:
          if (!empty && !flush) begin
            pop     = 1'b1;
            state_d = hit ? S_DWAIT : S_AWAIT;
          end
        S_AWAIT:
          if (!busy) begin
            state_d = S_AWR;
            cnt_d   = CW'(STROBE - 1);
          end
        S_AWR: begin
          state_d = tick_end ? S_AGAP : S_AWR;
          cnt_d   = tick_end ? CW'(GAP - 1) : cnt_q - CW'(1);
        end
        S_AGAP: begin
          state_d = tick_end ? S_DWAIT : S_AGAP;
          cnt_d   = cnt_q - CW'(1);
        end
        S_DWAIT:
          if (!busy) begin
            state_d = S_DWR;
            cnt_d   = CW'(STROBE - 1);
          end
        S_DWR: begin
          state_d = tick_end ? S_DGAP : S_DWR;
          cnt_d   = tick_end ? CW'(GAP - 1) : cnt_q - CW'(1);
        end
        S_DGAP: begin
          state_d = tick_end ? S_IDLE : S_DGAP;
          cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
  end

  always_comb begin
    stb_n_d = !(state_d == S_AWR || state_d == S_DWR);
    addr_d  = state_d == S_AWR ? {cur_d.part, 1'b0} : state_d == S_DWR ? {cur_d.part, 1'b1} : addr_q;
    dout_d  = state_d == S_AWR ? cur_d.rg : state_d == S_DWR ? cur_d.data : dout_q;
  end

  assign req_ready = !full;
  assign cs_n      = stb_n_q;
  assign wr_n      = stb_n_q;
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign level     = fifo_level;
  assign overflow  = ov_q;
  assign idle      = empty && state_q == S_IDLE;
endmodule

// File: tb/tb_jt12_wr_queue.sv
// tb_jt12_wr_queue: directed self-checking bench for jt12_wr_queue
module tb_jt12_wr_queue;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, cen = 1, req_valid = 0, req_part = 0, flush = 0, busy = 0;
  logic [7:0] req_reg = 0, req_data = 0;
  logic req_ready, cs_n, wr_n, overflow, idle;
  logic [1:0] addr;
  logic [7:0] dout;
  logic [4:0] level;
  int checks = 0, failures = 0, cen_per = 1, cph = 0, idle_run = 0;
  logic prev_cs = 1;
  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    int w;
    int g;
  } rec_t;
  rec_t cur_rec;
  rec_t log_q[$];
  rec_t exp_q[$];

  jt12_wr_queue #(.DEPTH(DEPTH), .STROBE(1), .GAP(2), .ADDR_CACHE(1)) dut (
    .clk(clk), .rst(rst), .cen(cen), .req_valid(req_valid), .req_ready(req_ready),
    .req_part(req_part), .req_reg(req_reg), .req_data(req_data), .flush(flush), .busy(busy),
    .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .dout(dout), .level(level),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cen_per == 0) cen = 0;
    else begin
      cen = (cph == 0);
      cph = (cph + 1 >= cen_per) ? 0 : cph + 1;
    end
  end

  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      if (prev_cs) begin
        cur_rec.a = addr;
        cur_rec.d = dout;
        cur_rec.w = 1;
        cur_rec.g = idle_run;
      end else cur_rec.w++;
    end else begin
      if (!prev_cs) begin
        log_q.push_back(cur_rec);
        idle_run = 0;
      end
      idle_run++;
    end
    prev_cs = (cs_n !== 1'b0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic push_one(input logic p, input logic [7:0] r, input logic [7:0] d);
    req_part = p;
    req_reg = r;
    req_data = d;
    req_valid = 1;
    step;
    req_valid = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i = 0;
    while (idle !== 1'b1 && i < budget) begin
      step;
      i++;
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: idle=%b after %0d cycles, expected 1", name, idle, budget);
    end
  endtask

  task automatic wait_strobe(input int budget, input string name);
    int i = 0;
    while (cs_n !== 1'b0 && i < budget) begin
      step;
      i++;
    end
    checks++;
    if (cs_n !== 1'b0) begin
      failures++;
      $display("FAIL %s_strobe_timeout: cs_n=%b after %0d cycles, expected 0", name, cs_n, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) step;
    checks++;
    if ({cs_n, wr_n, addr, dout} !== {1'b1, 1'b1, 2'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_bus: got cs_n=%b wr_n=%b addr=%0d dout=%h expected 1 1 0 00", cs_n, wr_n, addr, dout);
    end
    checks++;
    if ({level, overflow, idle, req_ready} !== {5'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_status: got level=%0d ovf=%b idle=%b ready=%b expected 0 0 1 1", level, overflow, idle, req_ready);
    end
    rst = 0;
    step;
  endtask

  task automatic test_single;
    log_q.delete();
    push_one(0, 8'h28, 8'hF0);
    checks++;
    if (level !== 5'd1 || cs_n !== 1'b1) begin
      failures++;
      $display("FAIL t1_after_push: got level=%0d cs_n=%b expected 1 1", level, cs_n);
    end
    step;
    checks++;
    if (cs_n !== 1'b1 || level !== 5'd0) begin
      failures++;
      $display("FAIL t1_pop: got cs_n=%b level=%0d expected 1 0", cs_n, level);
    end
    step;
    checks++;
    if ({cs_n, wr_n, addr, dout} !== {1'b0, 1'b0, 2'd0, 8'h28}) begin
      failures++;
      $display("FAIL t1_addr_strobe: got cs_n=%b wr_n=%b addr=%0d dout=%h expected 0 0 0 28", cs_n, wr_n, addr, dout);
    end
    wait_done(100, "t1");
    checks++;
    if (log_q.size() != 2) begin
      failures++;
      $display("FAIL t1_count: got %0d writes expected 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].a !== 2'd0 || log_q[0].d !== 8'h28 || log_q[0].w != 1) begin
        failures++;
        $display("FAIL t1_addr_wr: got a=%0d d=%h w=%0d expected 0 28 1", log_q[0].a, log_q[0].d, log_q[0].w);
      end
      checks++;
      if (log_q[1].a !== 2'd1 || log_q[1].d !== 8'hF0 || log_q[1].w != 1 || log_q[1].g != 3) begin
        failures++;
        $display("FAIL t1_data_wr: got a=%0d d=%h w=%0d gap=%0d expected 1 F0 1 3", log_q[1].a, log_q[1].d, log_q[1].w, log_q[1].g);
      end
    end
  endtask

  task automatic test_cache;
    log_q.delete();
    exp_q.delete();
    req_part = 1;
    req_reg = 8'hB4;
    req_data = 8'hC0;
    req_valid = 1;
    step;
    step;
    req_valid = 0;
    checks++;
    if (level !== 5'd1) begin
      failures++;
      $display("FAIL t2_push_pop_level: got %0d expected 1", level);
    end
    wait_done(100, "t2a");
    push_one(0, 8'h28, 8'h11);
    wait_done(100, "t2b");
    exp_q.push_back('{a: 2'd2, d: 8'hB4, w: 1, g: 0});
    exp_q.push_back('{a: 2'd3, d: 8'hC0, w: 1, g: 0});
    exp_q.push_back('{a: 2'd3, d: 8'hC0, w: 1, g: 0});
    exp_q.push_back('{a: 2'd1, d: 8'h11, w: 1, g: 0});
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t2_count: got %0d writes expected %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= log_q.size() || log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d || log_q[i].w != exp_q[i].w) begin
        failures++;
        $display("FAIL t2_write%0d: expected a=%0d d=%h w=%0d", i, exp_q[i].a, exp_q[i].d, exp_q[i].w);
      end
    end
  endtask

  task automatic test_busy;
    int bad = 0;
    log_q.delete();
    push_one(0, 8'h30, 8'h55);
    wait_strobe(20, "t3");
    busy = 1;
    repeat (50) begin
      step;
      if (cs_n !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t3_hold: got %0d strobe cycles while busy expected 0", bad);
    end
    busy = 0;
    step;
    checks++;
    if ({cs_n, addr, dout} !== {1'b0, 2'd1, 8'h55}) begin
      failures++;
      $display("FAIL t3_release: got cs_n=%b addr=%0d dout=%h expected 0 1 55", cs_n, addr, dout);
    end
    wait_done(100, "t3");
  endtask

  task automatic test_overflow;
    log_q.delete();
    exp_q.delete();
    busy = 1;
    cen_per = 0;
    step;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k == DEPTH) begin
        checks++;
        if (req_ready !== 1'b0 || level !== 5'(DEPTH) || overflow !== 1'b0) begin
          failures++;
          $display("FAIL t4_full: got ready=%b level=%0d ovf=%b expected 0 %0d 0", req_ready, level, overflow, DEPTH);
        end
      end
      push_one(k[0], 8'(8'h40 + k), 8'(k));
      if (k < DEPTH) begin
        exp_q.push_back('{a: {k[0], 1'b0}, d: 8'(8'h40 + k), w: 1, g: 0});
        exp_q.push_back('{a: {k[0], 1'b1}, d: 8'(k), w: 1, g: 0});
      end
    end
    checks++;
    if (overflow !== 1'b1 || level !== 5'(DEPTH)) begin
      failures++;
      $display("FAIL t4_overflow: got ovf=%b level=%0d expected 1 %0d", overflow, level, DEPTH);
    end
    busy = 0;
    cen_per = 1;
    wait_done(1000, "t4");
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t4_count: got %0d writes expected %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= log_q.size() || log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d || log_q[i].w != exp_q[i].w) begin
        failures++;
        $display("FAIL t4_write%0d: expected a=%0d d=%h w=%0d", i, exp_q[i].a, exp_q[i].d, exp_q[i].w);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL t4_sticky: got ovf=%b expected 1", overflow);
    end
    flush = 1;
    step;
    flush = 0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL t4_flush_clear: got ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_cen;
    int i = 0;
    log_q.delete();
    exp_q.delete();
    cen_per = 6;
    step;
    while (cen !== 1'b1 && i < 12) begin
      step;
      i++;
    end
    req_part = 1;
    req_reg = 8'h60;
    req_data = 8'h77;
    req_valid = 1;
    step;
    checks++;
    if (level !== 5'd1) begin
      failures++;
      $display("FAIL t5_push0: got level=%0d expected 1", level);
    end
    req_data = 8'h78;
    step;
    checks++;
    if (level !== 5'd2) begin
      failures++;
      $display("FAIL t5_push1: got level=%0d expected 2", level);
    end
    req_part = 0;
    req_reg = 8'h61;
    req_data = 8'h79;
    step;
    req_valid = 0;
    checks++;
    if (level !== 5'd3) begin
      failures++;
      $display("FAIL t5_push2: got level=%0d expected 3", level);
    end
    wait_done(2000, "t5");
    exp_q.push_back('{a: 2'd2, d: 8'h60, w: 6, g: 0});
    exp_q.push_back('{a: 2'd3, d: 8'h77, w: 6, g: 18});
    exp_q.push_back('{a: 2'd3, d: 8'h78, w: 6, g: 24});
    exp_q.push_back('{a: 2'd0, d: 8'h61, w: 6, g: 0});
    exp_q.push_back('{a: 2'd1, d: 8'h79, w: 6, g: 18});
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t5_count: got %0d writes expected %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= log_q.size() || log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d || log_q[i].w != exp_q[i].w
          || (exp_q[i].g != 0 && log_q[i].g != exp_q[i].g)) begin
        failures++;
        $display("FAIL t5_write%0d: expected a=%0d d=%h w=%0d gap=%0d", i, exp_q[i].a, exp_q[i].d, exp_q[i].w, exp_q[i].g);
      end
    end
    cen_per = 1;
    step;
    step;
  endtask

  task automatic test_flush;
    log_q.delete();
    exp_q.delete();
    push_one(0, 8'h70, 8'h01);
    wait_strobe(20, "t6");
    busy = 1;
    for (int k = 0; k < 5; k++) push_one(1, 8'(8'h80 + k), 8'(k));
    repeat (3) step;
    checks++;
    if (level !== 5'd5 || idle !== 1'b0 || cs_n !== 1'b1) begin
      failures++;
      $display("FAIL t6_queued: got level=%0d idle=%b cs_n=%b expected 5 0 1", level, idle, cs_n);
    end
    flush = 1;
    req_part = 0;
    req_reg = 8'h71;
    req_data = 8'h33;
    req_valid = 1;
    step;
    flush = 0;
    req_valid = 0;
    checks++;
    if (level !== 5'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL t6_flush: got level=%0d ovf=%b expected 0 0", level, overflow);
    end
    busy = 0;
    wait_done(100, "t6a");
    push_one(0, 8'h70, 8'h02);
    wait_done(100, "t6b");
    exp_q.push_back('{a: 2'd0, d: 8'h70, w: 1, g: 0});
    exp_q.push_back('{a: 2'd1, d: 8'h01, w: 1, g: 0});
    exp_q.push_back('{a: 2'd0, d: 8'h70, w: 1, g: 0});
    exp_q.push_back('{a: 2'd1, d: 8'h02, w: 1, g: 0});
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t6_count: got %0d writes expected %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= log_q.size() || log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d || log_q[i].w != exp_q[i].w) begin
        failures++;
        $display("FAIL t6_write%0d: expected a=%0d d=%h w=%0d", i, exp_q[i].a, exp_q[i].d, exp_q[i].w);
      end
    end
  endtask

  task automatic test_mid_reset;
    log_q.delete();
    push_one(1, 8'h90, 8'hAA);
    wait_strobe(20, "t6r");
    rst = 1;
    step;
    checks++;
    if ({cs_n, wr_n, addr, dout} !== {1'b1, 1'b1, 2'd0, 8'd0}) begin
      failures++;
      $display("FAIL t6_rst_bus: got cs_n=%b wr_n=%b addr=%0d dout=%h expected 1 1 0 00", cs_n, wr_n, addr, dout);
    end
    checks++;
    if (idle !== 1'b1 || level !== 5'd0) begin
      failures++;
      $display("FAIL t6_rst_status: got idle=%b level=%0d expected 1 0", idle, level);
    end
    rst = 0;
    repeat (20) step;
    checks++;
    if (log_q.size() != 1) begin
      failures++;
      $display("FAIL t6_no_retry: got %0d writes expected 1", log_q.size());
    end
    push_one(1, 8'h90, 8'hBB);
    wait_done(100, "t6r");
    checks++;
    if (log_q.size() != 3 || log_q[1].a !== 2'd2 || log_q[1].d !== 8'h90 || log_q[2].a !== 2'd3 || log_q[2].d !== 8'hBB) begin
      failures++;
      $display("FAIL t6_rst_cache: got %0d writes, expected addr write 2/90 then data 3/BB", log_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_cache;
    test_busy;
    test_overflow;
    test_cen;
    test_flush;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
